// File: rtl/battleship_pkg.sv
// Shared types, fixed fleet layout and cell lookup helpers for the shot tracker.
// Pure combinational helpers; no state lives here.
package battleship_pkg;

  typedef logic [3:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    WAIT_REL
  } state_t;

  localparam int         NUM_SHIPS = 5;
  localparam logic [2:0] NO_SHIP   = 3'd7;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    logic   horiz;
  } ship_pos_t;

  // Ship i starts at (x0,y0) and extends SHIP_LEN[i] cells rightwards or downwards.
  localparam int SHIP_LEN [NUM_SHIPS] = '{5, 4, 3, 3, 2};
  localparam ship_pos_t SHIP_POS [NUM_SHIPS] = '{
    '{4'd2, 4'd2, 1'b1},
    '{4'd9, 4'd3, 1'b0},
    '{4'd4, 4'd8, 1'b1},
    '{4'd2, 4'd5, 1'b0},
    '{4'd8, 4'd10, 1'b1}
  };

  function automatic logic on_board(coord_t c);
    return (c >= 4'd1) && (c <= 4'd10);
  endfunction

  function automatic logic [2:0] ship_id(coord_t x, coord_t y);
    logic [2:0] id;
    int         xi;
    int         yi;
    int         x0;
    int         y0;
    id = NO_SHIP;
    xi = int'(x);
    yi = int'(y);
    for (int i = 0; i < NUM_SHIPS; i++) begin
      x0 = int'(SHIP_POS[i].x0);
      y0 = int'(SHIP_POS[i].y0);
      if (SHIP_POS[i].horiz) begin
        if (yi == y0 && xi >= x0 && xi < x0 + SHIP_LEN[i]) id = 3'(i);
      end else begin
        if (xi == x0 && yi >= y0 && yi < y0 + SHIP_LEN[i]) id = 3'(i);
      end
    end
    return id;
  endfunction

  function automatic logic is_ship(coord_t x, coord_t y);
    return ship_id(x, y) != NO_SHIP;
  endfunction

  // Neighbour coordinates wrap to 15 or reach 11 at the edges; neither is a ship cell.
  function automatic logic near_ship(coord_t x, coord_t y);
    logic n;
    n = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0)
          n = n | is_ship(4'(int'(x) + dx), 4'(int'(y) + dy));
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Brings the raw active-low key into the clock domain and flags the press edge.
// press is high for the single cycle where the synchronized key first reads low.
module key_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press
);

  logic sync1;
  logic sync2;
  logic hist;

  // Idle level of the key is high, so reset to released rather than pressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign key_level = sync2;
  assign press     = ~sync2 & hist;

endmodule

// File: rtl/shot_tracker.sv
// Validates a shot, scans one cell per cycle against the fleet and commits results.
// Outputs move 2 edges after the press (10 for a big bomb); held keys never re-fire.
module shot_tracker
  import battleship_pkg::*;
#(
  parameter int BIG_BOMBS   = 2,
  parameter int LED_W       = 6,
  parameter int TOTAL_CELLS = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  input  logic             big,
  input  logic             score_n,
  output logic [LED_W-1:0] hit_led,
  output logic [LED_W-1:0] near_led,
  output logic [LED_W-1:0] miss_led,
  output logic [3:0]       hits_tens,
  output logic [3:0]       hits_ones,
  output logic [1:0]       bigs_left,
  output logic             wrong,
  output logic [4:0]       ship_hit,
  output logic             game_over
);

  localparam logic [1:0] BIG_INIT = 2'(BIG_BOMBS);
  localparam logic [4:0] TOTAL    = 5'(TOTAL_CELLS);

  state_t          state;
  logic            key_level;
  logic            press;

  coord_t          shot_x;
  coord_t          shot_y;
  logic            shot_big;
  logic [1:0]      off_x;
  logic [1:0]      off_y;

  logic            any_hit;
  logic            any_adj;
  logic [3:0]      new_hits;
  logic [4:0]      ship_acc;
  logic [9:0][9:0] hit_map;
  logic [4:0]      count;

  coord_t          cell_x;
  coord_t          cell_y;
  logic            cell_on;
  logic [2:0]      cell_id;
  logic            cell_ship;
  logic            cell_adj;
  logic            cell_new;
  logic            last_cell;
  logic            shot_ok;
  logic [5:0]      sum;
  logic [4:0]      count_nxt;

  key_sync_edge u_key (
    .clock     (clock),
    .reset     (reset),
    .key_n     (score_n),
    .key_level (key_level),
    .press     (press)
  );

  // Offsets run 0..2 and are centred by the -1; a normal shot sits at offset (1,1).
  assign cell_x    = shot_x + 4'(off_x) - 4'd1;
  assign cell_y    = shot_y + 4'(off_y) - 4'd1;
  assign cell_on   = on_board(cell_x) && on_board(cell_y);
  assign cell_id   = ship_id(cell_x, cell_y);
  assign cell_ship = cell_on && (cell_id != NO_SHIP);
  assign cell_adj  = cell_on && near_ship(cell_x, cell_y);
  assign cell_new  = cell_ship && !hit_map[cell_y - 4'd1][cell_x - 4'd1];
  assign last_cell = !shot_big || (off_x == 2'd2 && off_y == 2'd2);

  assign shot_ok   = on_board(x) && on_board(y) && !(big && bigs_left == 2'd0);

  assign sum       = {1'b0, count} + {2'b00, new_hits};
  assign count_nxt = (sum >= {1'b0, TOTAL}) ? TOTAL : sum[4:0];

  always_comb begin
    hits_tens = 4'd0;
    hits_ones = 4'(count);
    if (count >= 5'd30) begin
      hits_tens = 4'd3;
      hits_ones = 4'(count - 5'd30);
    end else if (count >= 5'd20) begin
      hits_tens = 4'd2;
      hits_ones = 4'(count - 5'd20);
    end else if (count >= 5'd10) begin
      hits_tens = 4'd1;
      hits_ones = 4'(count - 5'd10);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hit_led   <= '0;
      near_led  <= '0;
      miss_led  <= '0;
      count     <= '0;
      bigs_left <= BIG_INIT;
      wrong     <= 1'b0;
      ship_hit  <= '0;
      game_over <= 1'b0;
      hit_map   <= '0;
      shot_x    <= '0;
      shot_y    <= '0;
      shot_big  <= 1'b0;
      off_x     <= '0;
      off_y     <= '0;
      any_hit   <= 1'b0;
      any_adj   <= 1'b0;
      new_hits  <= '0;
      ship_acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press && !game_over) begin
            if (!shot_ok) begin
              wrong <= 1'b1;
              state <= WAIT_REL;
            end else begin
              shot_x   <= x;
              shot_y   <= y;
              shot_big <= big;
              off_x    <= big ? 2'd0 : 2'd1;
              off_y    <= big ? 2'd0 : 2'd1;
              any_hit  <= 1'b0;
              any_adj  <= 1'b0;
              new_hits <= '0;
              ship_acc <= '0;
              state    <= SCAN;
            end
          end
        end

        SCAN: begin
          any_hit <= any_hit | cell_ship;
          any_adj <= any_adj | cell_adj;
          if (cell_new) begin
            hit_map[cell_y - 4'd1][cell_x - 4'd1] <= 1'b1;
            new_hits          <= new_hits + 4'd1;
            ship_acc[cell_id] <= 1'b1;
          end
          if (last_cell) begin
            state <= COMMIT;
          end else if (off_x == 2'd2) begin
            off_x <= 2'd0;
            off_y <= off_y + 2'd1;
          end else begin
            off_x <= off_x + 2'd1;
          end
        end

        COMMIT: begin
          hit_led  <= {LED_W{any_hit}};
          near_led <= {LED_W{!any_hit && any_adj}};
          miss_led <= {LED_W{!any_hit && !any_adj}};
          count    <= count_nxt;
          ship_hit <= ship_hit | ship_acc;
          wrong    <= 1'b0;
          if (shot_big) bigs_left <= bigs_left - 2'd1;
          if (count_nxt == TOTAL) game_over <= 1'b1;
          state <= WAIT_REL;
        end

        WAIT_REL: begin
          if (key_level) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_tracker.sv
// Table-driven bench for shot_tracker with a queue of expected result snapshots.
// Hand sequences cover reset values and a reset landing in the middle of a big-bomb scan.
module tb_shot_tracker;

  localparam int LED_W  = 6;
  localparam int ACCEPT = 0;
  localparam int REJECT = 1;
  localparam int IGNORE = 2;
  localparam int R_NONE = 0;
  localparam int R_HIT  = 1;
  localparam int R_NEAR = 2;
  localparam int R_MISS = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       x;
  logic [3:0]       y;
  logic             big;
  logic             score_n;
  logic [LED_W-1:0] hit_led;
  logic [LED_W-1:0] near_led;
  logic [LED_W-1:0] miss_led;
  logic [3:0]       hits_tens;
  logic [3:0]       hits_ones;
  logic [1:0]       bigs_left;
  logic             wrong;
  logic [4:0]       ship_hit;
  logic             game_over;

  shot_tracker #(
    .BIG_BOMBS   (2),
    .LED_W       (LED_W),
    .TOTAL_CELLS (17)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .big       (big),
    .score_n   (score_n),
    .hit_led   (hit_led),
    .near_led  (near_led),
    .miss_led  (miss_led),
    .hits_tens (hits_tens),
    .hits_ones (hits_ones),
    .bigs_left (bigs_left),
    .wrong     (wrong),
    .ship_hit  (ship_hit),
    .game_over (game_over)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [LED_W-1:0] hit;
    logic [LED_W-1:0] near;
    logic [LED_W-1:0] miss;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [1:0]       bigs;
    logic             wrong;
    logic [4:0]       ship;
    logic             go;
  } obs_t;

  typedef struct {
    int x; int y; int big; int hold; int kind;
    int res; int cnt; int bigs; int wrong; int ship; int go;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t prev;
  obs_t rst_obs;
  obs_t sb[$];
  vec_t vecs[22];

  function automatic obs_t sample();
    obs_t o;
    o.hit   = hit_led;
    o.near  = near_led;
    o.miss  = miss_led;
    o.tens  = hits_tens;
    o.ones  = hits_ones;
    o.bigs  = bigs_left;
    o.wrong = wrong;
    o.ship  = ship_hit;
    o.go    = game_over;
    return o;
  endfunction

  function automatic obs_t mk_exp(input vec_t v);
    obs_t o;
    o.hit   = {LED_W{v.res == R_HIT}};
    o.near  = {LED_W{v.res == R_NEAR}};
    o.miss  = {LED_W{v.res == R_MISS}};
    o.tens  = 4'(v.cnt / 10);
    o.ones  = 4'(v.cnt % 10);
    o.bigs  = 2'(v.bigs);
    o.wrong = (v.wrong != 0);
    o.ship  = 5'(v.ship);
    o.go    = (v.go != 0);
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Press at the negedge before edge 1; the FSM samples the press on edge 3.
  task automatic do_shot(input string name, input vec_t v);
    obs_t e;
    obs_t got_e;
    int   lat;
    int   total;
    e     = mk_exp(v);
    lat   = (v.kind == REJECT) ? 3 : ((v.big != 0) ? 13 : 5);
    total = ((lat > v.hold) ? lat : v.hold) + 6;
    @(negedge clock);
    x       = 4'(v.x);
    y       = 4'(v.y);
    big     = (v.big != 0);
    score_n = 1'b0;
    sb.push_back(e);
    for (int k = 1; k <= total; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 3) begin
        x   = 4'($urandom_range(0, 15));
        y   = 4'($urandom_range(0, 15));
        big = 1'($urandom_range(0, 1));
      end
      if (k == v.hold) score_n = 1'b1;
      if (k == lat - 1 && v.kind != REJECT) check({name, " early"}, prev);
      if (k == lat) begin
        got_e = sb.pop_front();
        check(name, got_e);
      end
    end
    check({name, " after release"}, e);
    prev = e;
  endtask

  initial begin
    vec_t tmp;
    //          x  y  big hold kind    res     cnt bigs wr ship go
    vecs[0]  = '{3, 2, 0, 4,  ACCEPT, R_HIT,  1,  2,  0, 1,  0};
    vecs[1]  = '{3, 2, 0, 4,  ACCEPT, R_HIT,  1,  2,  0, 1,  0};
    vecs[2]  = '{5, 5, 0, 4,  ACCEPT, R_MISS, 1,  2,  0, 1,  0};
    vecs[3]  = '{8, 4, 0, 4,  ACCEPT, R_NEAR, 1,  2,  0, 1,  0};
    vecs[4]  = '{9, 4, 1, 14, ACCEPT, R_HIT,  4,  1,  0, 3,  0};
    vecs[5]  = '{0, 5, 0, 4,  REJECT, R_HIT,  4,  1,  1, 3,  0};
    vecs[6]  = '{5, 5, 0, 4,  ACCEPT, R_MISS, 4,  1,  0, 3,  0};
    vecs[7]  = '{5, 11, 0, 4, REJECT, R_MISS, 4,  1,  1, 3,  0};
    vecs[8]  = '{9, 10, 1, 50, ACCEPT, R_HIT, 6,  0,  0, 19, 0};
    vecs[9]  = '{1, 1, 1, 4,  REJECT, R_HIT,  6,  0,  1, 19, 0};
    vecs[10] = '{2, 2, 0, 4,  ACCEPT, R_HIT,  7,  0,  0, 19, 0};
    vecs[11] = '{4, 2, 0, 4,  ACCEPT, R_HIT,  8,  0,  0, 19, 0};
    vecs[12] = '{5, 2, 0, 4,  ACCEPT, R_HIT,  9,  0,  0, 19, 0};
    vecs[13] = '{6, 2, 0, 4,  ACCEPT, R_HIT,  10, 0,  0, 19, 0};
    vecs[14] = '{9, 6, 0, 4,  ACCEPT, R_HIT,  11, 0,  0, 19, 0};
    vecs[15] = '{4, 8, 0, 4,  ACCEPT, R_HIT,  12, 0,  0, 23, 0};
    vecs[16] = '{5, 8, 0, 4,  ACCEPT, R_HIT,  13, 0,  0, 23, 0};
    vecs[17] = '{6, 8, 0, 4,  ACCEPT, R_HIT,  14, 0,  0, 23, 0};
    vecs[18] = '{2, 5, 0, 4,  ACCEPT, R_HIT,  15, 0,  0, 31, 0};
    vecs[19] = '{2, 6, 0, 4,  ACCEPT, R_HIT,  16, 0,  0, 31, 0};
    vecs[20] = '{2, 7, 0, 4,  ACCEPT, R_HIT,  17, 0,  0, 31, 1};
    vecs[21] = '{5, 5, 0, 4,  IGNORE, R_HIT,  17, 0,  0, 31, 1};

    tmp     = '{0, 0, 0, 0, ACCEPT, R_NONE, 0, 2, 0, 0, 0};
    rst_obs = mk_exp(tmp);

    reset   = 1'b1;
    score_n = 1'b1;
    x       = 4'd0;
    y       = 4'd0;
    big     = 1'b0;
    repeat (2) @(negedge clock);
    check("reset held", rst_obs);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset released", rst_obs);
    prev = rst_obs;

    for (int i = 0; i < 22; i++) do_shot($sformatf("vec%0d", i), vecs[i]);

    // Fresh game, one hit, then reset lands mid big-bomb scan.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("second reset", rst_obs);
    prev = rst_obs;
    tmp  = '{3, 2, 0, 4, ACCEPT, R_HIT, 1, 2, 0, 1, 0};
    do_shot("rehit after reset", tmp);

    @(negedge clock);
    x       = 4'd9;
    y       = 4'd4;
    big     = 1'b1;
    score_n = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset   = 1'b1;
    score_n = 1'b1;
    #1;
    check("reset mid scan", rst_obs);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("after mid-scan reset", rst_obs);
    prev = rst_obs;
    tmp  = '{9, 4, 0, 4, ACCEPT, R_HIT, 1, 2, 0, 2, 0};
    do_shot("shot after discarded scan", tmp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_tracker.md
Name: shot_tracker

Overview:
- Sequential game-state stage that sits upstream of the hit/wrong display logic and the seven-segment drivers.
- Synchronizes and edge-detects the "score this" key, then validates the shot (coordinates, big-bomb inventory).
- Scans the targeted cell(s) against a fixed ship layout and keeps a 100-cell already-hit map and the big-bomb inventory.
- Produces registered result LEDs, BCD hit count, wrong flag and per-ship hit flags for the downstream displays.

Parameters:
BIG_BOMBS, 2, big bombs available after reset (1..3)
LED_W, 6, width of each of the hit / near-miss / miss LED groups
TOTAL_CELLS, 17, ship cells on the board; reaching this count ends the game

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
x  in  4  column, valid 1..10
y  in  4  row, valid 1..10
big  in  1  1 = big bomb (3x3 area centred on x,y)
score_n  in  1  raw KEY0, active low, asynchronous to clock
hit_led  out  LED_W  all ones when last shot hit
near_led  out  LED_W  all ones when last shot was a near miss
miss_led  out  LED_W  all ones when last shot missed
hits_tens  out  4  BCD tens of cumulative distinct ship cells hit
hits_ones  out  4  BCD ones of same
bigs_left  out  2  remaining big bombs
wrong  out  1  last press was rejected
ship_hit  out  5  bit i set once ship i has any cell hit (0 = length 5 … 4 = length 2)
game_over  out  1  all TOTAL_CELLS hit

Behaviour:
- Reset values:
  - hit_led, near_led, miss_led = 0
  - hits_tens = 0, hits_ones = 0
  - bigs_left = BIG_BOMBS
  - wrong = 0, ship_hit = 0, game_over = 0
  - hit map cleared; FSM in IDLE
  - Reset is honoured mid-scan: an in-flight shot is discarded.
- Input sync:
  - score_n passes through a 2-FF synchronizer plus one history FF.
  - Press cycle P = synchronized value 0 and history value 1.
- Ship layout (x,y), fixed:
  - ship0: (2..6, 2)
  - ship1: (9, 3..6)
  - ship2: (4..6, 8)
  - ship3: (2, 5..7)
  - ship4: (8..9, 10)
- FSM states: IDLE, SCAN, COMMIT, WAIT_REL.
  - IDLE, press at P with game_over = 0:
    - Rejected if x or y is outside 1..10, or big = 1 with bigs_left = 0.
    - Rejected press: wrong <= 1, other outputs hold, go to WAIT_REL.
    - Accepted press: capture x, y, big; clear scan accumulators; go to SCAN.
  - IDLE, press with game_over = 1: ignored, no output change.
  - SCAN: one cell per cycle.
    - Normal shot: 1 cell.
    - Big shot: offsets (-1..+1, -1..+1) in row-major order, 9 cycles.
    - Cells off the board (0 or 11) still take a cycle but contribute nothing.
    - Per cell:
      - any_hit |= ship(cell)
      - any_adj |= ship in any of its 8 neighbours
      - If ship(cell) and not map(cell): set map(cell), new_hits += 1, set ship_hit[id].
  - COMMIT, one cycle:
    - Exactly one LED group is all ones: hit if any_hit; else near if any_adj; else miss.
    - Hit count += new_hits; BCD updated in the same edge.
    - wrong <= 0.
    - bigs_left decremented if the shot was big.
    - game_over <= 1 when the count reaches TOTAL_CELLS.
    - Go to WAIT_REL.
  - WAIT_REL: stay until the synchronized key reads 1, then go to IDLE. A held key never re-fires.
- Latency: outputs change at edge P+2 for a normal shot and P+10 for a big shot.
- Operand stability: x, y and big changes after P do not affect the shot in flight.
- Re-shooting an already-hit ship cell: lights hit_led, adds 0 to the count.
- Count is 5-bit binary, saturating at TOTAL_CELLS, and never wraps.

Decomposition:
- battleship_pkg holds:
  - coord_t (logic [3:0])
  - state enum
  - SHIP_LEN and SHIP_POS constants
  - functions is_ship(x,y), ship_id(x,y), near_ship(x,y)
- One sub-module: key_sync_edge, which contains the 2-FF synchronizer, history FF and press pulse.
- The BCD split is combinational from the registered count, inside shot_tracker.

Test Plan:
- Reset, then press at (3,2) normal → at P+2: hit_led = 6'h3F, hits = 0,1, ship_hit = 5'b00001, wrong = 0.
- Same press repeated → hit_led = 3F, count stays 1.
- Press at (5,5) normal, which is adjacent to no ship → miss_led = 3F. Then press at (8,4) → near_led = 3F.
- Big at (9,4) → at P+10: hit_led, 3 new hits (9,3),(9,4),(9,5), bigs_left = 1. Second big somewhere → bigs_left = 0. Third big → wrong = 1, bigs_left = 0, LEDs unchanged.
- Press with x = 0 or y = 11 → wrong = 1. A following valid miss → wrong = 0.
- Hold score_n low for 50 cycles → exactly one shot.
- Hit all 17 cells → hits = 1,7, game_over = 1, ship_hit = 1F. A further press changes nothing.
- Assert reset during a big-bomb scan → all outputs return to reset values within the same cycle.
